// File: rtl/core_control_fsm_pkg.sv
// -----------------------------------------------------------------------------
// core_control_fsm_pkg
// Shared definitions for the RISCuinho multi-cycle control sequencer:
//   - state encoding (also visible on the debug `state` port)
//   - RV32I major opcode constants
//   - trap cause and PC source codes
//   - opcode legality helpers used in DECODE
// -----------------------------------------------------------------------------
package core_control_fsm_pkg;

    typedef enum logic [2:0] {
        ST_RESET     = 3'd0,
        ST_FETCH     = 3'd1,
        ST_DECODE    = 3'd2,
        ST_EXECUTE   = 3'd3,
        ST_MEM       = 3'd4,
        ST_WRITEBACK = 3'd5,
        ST_TRAP      = 3'd6
    } state_t;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    typedef enum logic [1:0] {
        TRAP_NONE    = 2'b00,
        TRAP_ILLEGAL = 2'b01,
        TRAP_SYSTEM  = 2'b10,
        TRAP_TIMEOUT = 2'b11
    } trap_cause_t;

    typedef enum logic [1:0] {
        PC_PLUS4 = 2'b00,   // pc + 4
        PC_REL   = 2'b01,   // pc + imm (JAL, taken branch)
        PC_JALR  = 2'b10    // (rs1 + imm) & ~1
    } pc_sel_t;

    // Opcodes the core can execute. SYSTEM is deliberately absent: it traps.
    function automatic logic is_legal_opcode(input logic [6:0] op);
        case (op)
            OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH,
            OP_LOAD, OP_STORE, OP_IMM, OP_REG, OP_FENCE: return 1'b1;
            default:                                     return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/core_control_fsm_if.sv
// -----------------------------------------------------------------------------
// core_control_fsm_if
// Instruction and data bus handshake between the control sequencer and the
// memory system.
//   imem_req  : instruction fetch request        (sequencer -> memory)
//   imem_ack  : instruction available this cycle (memory -> sequencer)
//   dmem_req  : data access request              (sequencer -> memory)
//   dmem_we   : data access is a write           (sequencer -> memory)
//   dmem_ack  : data access completes this cycle (memory -> sequencer)
// -----------------------------------------------------------------------------
interface core_control_fsm_if;

    logic imem_req;
    logic imem_ack;
    logic dmem_req;
    logic dmem_we;
    logic dmem_ack;

    modport master (
        output imem_req, dmem_req, dmem_we,
        input  imem_ack, dmem_ack
    );

    modport slave (
        input  imem_req, dmem_req, dmem_we,
        output imem_ack, dmem_ack
    );

endinterface

// File: rtl/core_control_fsm_wait_counter.sv
// -----------------------------------------------------------------------------
// ctrl_wait_counter
// Counts unacknowledged bus request cycles for the control sequencer.
//   clk, reset_n : core clock, asynchronous active-low reset
//   clear        : restart counting (a new request phase begins)
//   inc          : one more request cycle went by without an ack
//   expired      : the current request cycle is the TIMEOUT_CYCLES-th one;
//                  if it is also not acked, the request has timed out
// -----------------------------------------------------------------------------
module ctrl_wait_counter #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic inc,
    output logic expired
);

    localparam int W = $clog2(TIMEOUT_CYCLES + 1);

    logic [W-1:0] cnt_q;

    // Flag the limit one count early so the sequencer can let a same-cycle
    // ack win over the timeout.
    assign expired = (cnt_q == W'(TIMEOUT_CYCLES - 1));

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (inc) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/core_control_fsm.sv
// -----------------------------------------------------------------------------
// core_control_fsm
// Multi-cycle sequencer for the RISCuinho integer core:
// RESET -> FETCH -> DECODE -> EXECUTE -> [MEM] -> WRITEBACK -> FETCH ...
// Illegal/system opcodes and bus timeouts park the core in a sticky TRAP.
//   clk, reset_n   : core clock, asynchronous active-low reset
//   bus            : instruction/data handshake (master side)
//   ir_we          : load IR, = imem_req & imem_ack
//   opcode, dec_*  : IR[6:0] and decoder flags, stable DECODE..WRITEBACK
//   branch_taken   : ALU compare result, sampled in EXECUTE
//   alu_en, reg_we, pc_we, pc_sel : datapath controls
//   state, halt, trap_cause, instret : status / debug
// All outputs except ir_we are registered and decoded from the next state,
// so they line up exactly with the state they belong to.
// -----------------------------------------------------------------------------
module core_control_fsm
    import core_control_fsm_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 32
) (
    input  logic                clk,
    input  logic                reset_n,
    core_control_fsm_if.master  bus,
    output logic                ir_we,
    input  logic [6:0]          opcode,
    input  logic                dec_jump,
    input  logic                dec_branch,
    input  logic                dec_data_r,
    input  logic                dec_data_w,
    input  logic                dec_reg_w,
    input  logic                branch_taken,
    output logic                alu_en,
    output logic                reg_we,
    output logic                pc_we,
    output logic [1:0]          pc_sel,
    output logic [2:0]          state,
    output logic                halt,
    output logic [1:0]          trap_cause,
    output logic [CNT_W-1:0]    instret
);

    state_t             state_q, state_d;
    trap_cause_t        cause_q, cause_d;
    pc_sel_t            pc_sel_q, pc_sel_d;
    logic               imem_req_q, dmem_req_q, dmem_we_q;
    logic               alu_en_q, reg_we_q, pc_we_q, halt_q;
    logic               taken_q;
    logic [CNT_W-1:0]   instret_q;

    logic               fetch_ack, mem_ack;
    logic               cnt_clear, cnt_inc, expired;
    logic               taken_now, jump_rel;

    // Acks only count while the matching request is up; stray acks are ignored.
    assign fetch_ack = bus.imem_req & bus.imem_ack;
    assign mem_ack   = bus.dmem_req & bus.dmem_ack;

    ctrl_wait_counter #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_wait_counter (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (cnt_clear),
        .inc     (cnt_inc),
        .expired (expired)
    );

    // Branch outcome is live in EXECUTE and held in taken_q afterwards, so
    // pc_sel is correct whether WRITEBACK follows EXECUTE or MEM.
    assign taken_now = (state_q == ST_EXECUTE) ? branch_taken : taken_q;
    // The decoder's jump flag covers JAL and JALR; JALR has its own source.
    assign jump_rel  = (opcode == OP_JAL) || (dec_jump && (opcode != OP_JALR));

    // NOTE: every signal gets a default before the case so no path through
    // this block leaves one unassigned and infers a latch.
    always_comb begin
        state_d   = state_q;
        cause_d   = cause_q;
        cnt_inc   = 1'b0;
        pc_sel_d  = PC_PLUS4;

        case (state_q)
            ST_RESET: state_d = ST_FETCH;

            ST_FETCH: begin
                if (fetch_ack) begin
                    state_d = ST_DECODE;
                end else begin
                    cnt_inc = 1'b1;
                    if (expired) begin
                        state_d = ST_TRAP;
                        cause_d = TRAP_TIMEOUT;
                    end
                end
            end

            ST_DECODE: begin
                if (opcode == OP_SYSTEM) begin
                    state_d = ST_TRAP;
                    cause_d = TRAP_SYSTEM;
                end else if (!is_legal_opcode(opcode)) begin
                    state_d = ST_TRAP;
                    cause_d = TRAP_ILLEGAL;
                end else begin
                    state_d = ST_EXECUTE;
                end
            end

            ST_EXECUTE: state_d = (dec_data_r || dec_data_w) ? ST_MEM : ST_WRITEBACK;

            ST_MEM: begin
                if (mem_ack) begin
                    state_d = ST_WRITEBACK;
                end else begin
                    cnt_inc = 1'b1;
                    if (expired) begin
                        state_d = ST_TRAP;
                        cause_d = TRAP_TIMEOUT;
                    end
                end
            end

            ST_WRITEBACK: state_d = ST_FETCH;

            ST_TRAP: state_d = ST_TRAP;

            default: begin
                state_d = ST_TRAP;
                cause_d = TRAP_ILLEGAL;
            end
        endcase

        if (state_d == ST_WRITEBACK) begin
            if (opcode == OP_JALR) begin
                pc_sel_d = PC_JALR;
            end else if (jump_rel || (dec_branch && taken_now)) begin
                pc_sel_d = PC_REL;
            end
        end
    end

    // Counter restarts on entry to a request phase, not on every cycle in it.
    assign cnt_clear = ((state_d == ST_FETCH) && (state_q != ST_FETCH)) ||
                       ((state_d == ST_MEM)   && (state_q != ST_MEM));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_RESET;
            cause_q    <= TRAP_NONE;
            pc_sel_q   <= PC_PLUS4;
            imem_req_q <= 1'b0;
            dmem_req_q <= 1'b0;
            dmem_we_q  <= 1'b0;
            alu_en_q   <= 1'b0;
            reg_we_q   <= 1'b0;
            pc_we_q    <= 1'b0;
            halt_q     <= 1'b0;
            taken_q    <= 1'b0;
            instret_q  <= '0;
        end else begin
            state_q    <= state_d;
            cause_q    <= cause_d;
            pc_sel_q   <= pc_sel_d;
            imem_req_q <= (state_d == ST_FETCH);
            dmem_req_q <= (state_d == ST_MEM);
            dmem_we_q  <= (state_d == ST_MEM) && dec_data_w;
            alu_en_q   <= (state_d == ST_EXECUTE);
            reg_we_q   <= (state_d == ST_WRITEBACK) && dec_reg_w;
            pc_we_q    <= (state_d == ST_WRITEBACK);
            halt_q     <= (state_d == ST_TRAP);
            if (state_q == ST_EXECUTE) begin
                taken_q <= branch_taken;
            end
            // Retirement is counted as WRITEBACK completes; wraps naturally.
            if (state_q == ST_WRITEBACK) begin
                instret_q <= instret_q + CNT_W'(1);
            end
        end
    end

    assign bus.imem_req = imem_req_q;
    assign bus.dmem_req = dmem_req_q;
    assign bus.dmem_we  = dmem_we_q;
    assign ir_we        = fetch_ack;
    assign alu_en       = alu_en_q;
    assign reg_we       = reg_we_q;
    assign pc_we        = pc_we_q;
    assign pc_sel       = pc_sel_q;
    assign state        = state_q;
    assign halt         = halt_q;
    assign trap_cause   = cause_q;
    assign instret      = instret_q;

endmodule
